// File: rtl/ucie_ctl_pkg.sv
// Shared definitions for the UCIe TX flow controller: FSM state encoding,
// the Active link-state code and the overflow counter increment.
package ucie_ctl_pkg;

   typedef enum logic [1:0] {
      ST_RESET    = 2'b00,
      ST_ACTIVE   = 2'b10,
      ST_OVERFLOW = 2'b11
   } tx_state_e;

   localparam logic [3:0] UCIE_STS_ACTIVE = 4'b0001;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a flush that empties it on the
// next edge; pointers carry one extra wrap bit to tell full from empty.
module ucie_ctl_sync_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              winc,
   input  logic              rinc,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [PW-1:0]     level
);

   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_en, rd_en;

   assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign level = wptr_q - rptr_q;
   // Drive zeros rather than stale storage when nothing is queued.
   assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   assign wr_en = winc & ~full & ~flush;
   assign rd_en = rinc & ~empty & ~flush;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_en) wptr_d = wptr_q + PW'(1);
         if (rd_en) rptr_d = rptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ucie_ctl_tx_flow_ctrl.sv
// TX flow controller between FDI and RDI: link-state FSM, handshakes,
// overflow detection/counting and almost-full warning around the FIFO.
module ucie_ctl_tx_flow_ctrl
   import ucie_ctl_pkg::*;
#(
   parameter int          DATA_W      = 64,
   parameter int          DEPTH       = 8,
   parameter int          AFULL_THR   = DEPTH - 2,
   parameter int          STICKY_OVF  = 1,
   parameter logic [3:0]  UCIE_ACTIVE = UCIE_STS_ACTIVE,
   localparam int         LW          = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        i_fdi_pl_state_sts,
   input  logic [DATA_W-1:0] i_fdi_lp_data,
   input  logic              i_fdi_lp_valid,
   input  logic              i_fdi_lp_irdy,
   output logic              o_fdi_pl_trdy,
   output logic [DATA_W-1:0] o_rdi_lp_data,
   output logic              o_rdi_lp_valid,
   output logic              o_rdi_lp_irdy,
   input  logic              i_rdi_pl_trdy,
   input  logic              i_ovf_clr,
   output logic              o_tx_overf_err,
   output logic [7:0]        o_ovf_cnt,
   output logic [LW-1:0]     o_fifo_level,
   output logic              o_afull
);

   tx_state_e         state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              afull_q, afull_d;
   logic              sts_active, beat, wr, rd, drop, flush;
   logic              full, empty;
   logic [LW-1:0]     level, level_nxt;

   assign sts_active = (i_fdi_pl_state_sts == UCIE_ACTIVE);
   assign beat       = i_fdi_lp_valid & i_fdi_lp_irdy;
   assign flush      = ~sts_active | (state_q == ST_RESET);

   // trdy depends only on FIFO fullness, never on the RDI side.
   always_comb begin
      o_fdi_pl_trdy  = 1'b0;
      o_rdi_lp_valid = 1'b0;
      o_tx_overf_err = 1'b0;
      case (state_q)
         ST_ACTIVE: begin
            o_fdi_pl_trdy  = ~full;
            o_rdi_lp_valid = ~empty;
            o_tx_overf_err = beat & full;
         end
         ST_OVERFLOW: begin
            o_rdi_lp_valid = ~empty;
            o_tx_overf_err = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_rdi_lp_irdy = o_rdi_lp_valid;
   assign wr            = beat & o_fdi_pl_trdy;
   assign rd            = o_rdi_lp_valid & i_rdi_pl_trdy;
   assign drop          = beat & ~o_fdi_pl_trdy & (state_q != ST_RESET);
   assign level_nxt     = flush ? '0 : level + LW'(wr) - LW'(rd);

   always_comb begin
      state_d = state_q;
      if (!sts_active) begin
         state_d = ST_RESET;
      end else begin
         case (state_q)
            ST_RESET:    state_d = ST_ACTIVE;
            ST_ACTIVE:   if (drop) state_d = ST_OVERFLOW;
            ST_OVERFLOW: if ((STICKY_OVF == 0) && i_ovf_clr && empty) state_d = ST_ACTIVE;
            default:     state_d = ST_RESET;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (i_ovf_clr || !sts_active) cnt_d = '0;
      else if (drop)                cnt_d = sat_inc8(cnt_q);
      afull_d = ~flush & (int'(level_nxt) >= AFULL_THR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         afull_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         afull_q <= afull_d;
      end
   end

   assign o_ovf_cnt    = cnt_q;
   assign o_afull      = afull_q;
   assign o_fifo_level = level;

   ucie_ctl_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .winc   (wr),
      .rinc   (rd),
      .flush  (flush),
      .wdata  (i_fdi_lp_data),
      .rdata  (o_rdi_lp_data),
      .full   (full),
      .empty  (empty),
      .level  (level)
   );

endmodule

// File: tb/tb_ucie_ctl_tx_flow_ctrl.sv
// Bench for the TX flow controller: a clearable and a sticky instance share
// stimulus and are each checked every cycle against a queue-based model.
module tb_ucie_ctl_tx_flow_ctrl;

   localparam int DW    = 64;
   localparam int DEPTH = 8;
   localparam int THR   = DEPTH - 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic [3:0]    sts = 4'h0;
   logic [DW-1:0] wdata = '0;
   logic          lv = 1'b0, li = 1'b0, rt = 1'b0, clr = 1'b0;

   logic          trdy  [2];
   logic [DW-1:0] rdat  [2];
   logic          rval  [2];
   logic          rirdy [2];
   logic          err   [2];
   logic [7:0]    ocnt  [2];
   logic [LW-1:0] lvl   [2];
   logic          afull [2];

   ucie_ctl_tx_flow_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THR(THR), .STICKY_OVF(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_fdi_pl_state_sts(sts), .i_fdi_lp_data(wdata),
      .i_fdi_lp_valid(lv), .i_fdi_lp_irdy(li), .o_fdi_pl_trdy(trdy[0]),
      .o_rdi_lp_data(rdat[0]), .o_rdi_lp_valid(rval[0]), .o_rdi_lp_irdy(rirdy[0]),
      .i_rdi_pl_trdy(rt), .i_ovf_clr(clr), .o_tx_overf_err(err[0]),
      .o_ovf_cnt(ocnt[0]), .o_fifo_level(lvl[0]), .o_afull(afull[0]));

   ucie_ctl_tx_flow_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THR(THR), .STICKY_OVF(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_fdi_pl_state_sts(sts), .i_fdi_lp_data(wdata),
      .i_fdi_lp_valid(lv), .i_fdi_lp_irdy(li), .o_fdi_pl_trdy(trdy[1]),
      .o_rdi_lp_data(rdat[1]), .o_rdi_lp_valid(rval[1]), .o_rdi_lp_irdy(rirdy[1]),
      .i_rdi_pl_trdy(rt), .i_ovf_clr(clr), .o_tx_overf_err(err[1]),
      .o_ovf_cnt(ocnt[1]), .o_fifo_level(lvl[1]), .o_afull(afull[1]));

   // Reference model: link up/down, overflow flag, data queue, drop count.
   bit            m_link [2];
   bit            m_ovf  [2];
   int            m_qn   [2];
   logic [DW-1:0] m_qd   [2][DEPTH];
   int            m_oc   [2];
   bit            m_afl  [2];
   bit            e_trdy [2];
   bit            e_val  [2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit r, input logic [3:0] s, input bit v, input bit i,
                       input bit t, input bit c, input bit do_chk);
      bit            act, beat, rd, wr, drop, was_empty;
      bit            e_err;
      logic [DW-1:0] e_dat;
      @(negedge clk);
      rst_n = ~r; sts = s; lv = v; li = i; rt = t; clr = c;
      wdata = {$urandom, $urandom};
      #1;
      for (int k = 0; k < 2; k++) begin
         e_trdy[k] = m_link[k] && !m_ovf[k] && (m_qn[k] < DEPTH);
         e_val[k]  = m_link[k] && (m_qn[k] > 0);
         e_dat     = e_val[k] ? m_qd[k][0] : '0;
         e_err     = m_link[k] && (m_ovf[k] || (v && i && m_qn[k] == DEPTH));
         if (do_chk) begin
            chk($sformatf("i%0d_trdy", k),  64'(trdy[k]),  64'(e_trdy[k]));
            chk($sformatf("i%0d_valid", k), 64'(rval[k]),  64'(e_val[k]));
            chk($sformatf("i%0d_irdy", k),  64'(rirdy[k]), 64'(e_val[k]));
            chk($sformatf("i%0d_data", k),  rdat[k],       e_dat);
            chk($sformatf("i%0d_err", k),   64'(err[k]),   64'(e_err));
            chk($sformatf("i%0d_cnt", k),   64'(ocnt[k]),  64'(m_oc[k]));
            chk($sformatf("i%0d_level", k), 64'(lvl[k]),   64'(m_qn[k]));
            chk($sformatf("i%0d_afull", k), 64'(afull[k]), 64'(m_afl[k]));
         end
      end
      @(posedge clk);
      act  = (s == 4'b0001);
      beat = v && i;
      for (int k = 0; k < 2; k++) begin
         if (r || !act) begin
            m_link[k] = 0; m_ovf[k] = 0; m_qn[k] = 0; m_oc[k] = 0; m_afl[k] = 0;
         end else if (!m_link[k]) begin
            m_link[k] = 1; m_oc[k] = 0; m_afl[k] = 0;
         end else begin
            rd        = e_val[k] && t;
            wr        = beat && e_trdy[k];
            drop      = beat && !e_trdy[k];
            was_empty = (m_qn[k] == 0);
            if (rd) begin
               for (int j = 0; j < DEPTH - 1; j++) m_qd[k][j] = m_qd[k][j+1];
               m_qn[k]--;
            end
            if (wr) begin
               m_qd[k][m_qn[k]] = wdata;
               m_qn[k]++;
            end
            if (c) m_oc[k] = 0;
            else if (drop && m_oc[k] < 255) m_oc[k]++;
            if (!m_ovf[k] && drop) m_ovf[k] = 1;
            else if (m_ovf[k] && k == 0 && c && was_empty) m_ovf[k] = 0;
            m_afl[k] = (m_qn[k] >= THR);
         end
      end
   endtask

   bit         up;
   int         bias;
   logic [3:0] s_rand;

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_link[k] = 0; m_ovf[k] = 0; m_qn[k] = 0; m_oc[k] = 0; m_afl[k] = 0;
      end
      step(1, 4'h0, 0, 0, 0, 0, 0);
      step(1, 4'h0, 0, 0, 0, 0, 0);
      step(0, 4'h0, 0, 0, 0, 0, 1);

      // Link up, five beats streamed straight through.
      step(0, 4'h1, 0, 0, 1, 0, 1);
      for (int n = 0; n < 5; n++) step(0, 4'h1, 1, 1, 1, 0, 1);
      for (int n = 0; n < 3; n++) step(0, 4'h1, 0, 0, 1, 0, 1);

      // RDI stalled: fill, overflow, then drain and clear.
      for (int n = 0; n < 10; n++) step(0, 4'h1, 1, 1, 0, 0, 1);
      for (int n = 0; n < 10; n++) step(0, 4'h1, 0, 1, 1, 0, 1);
      step(0, 4'h1, 0, 0, 1, 1, 1);
      for (int n = 0; n < 3; n++) step(0, 4'h1, 1, 1, 1, 0, 1);

      // Link drops at level 4, then comes back with fresh beats.
      for (int n = 0; n < 8; n++) step(0, 4'h1, 0, 0, 1, 0, 1);
      for (int n = 0; n < 4; n++) step(0, 4'h1, 1, 1, 0, 0, 1);
      step(0, 4'h0, 1, 1, 1, 0, 1);
      step(0, 4'h0, 0, 0, 1, 0, 1);
      step(0, 4'h1, 0, 0, 1, 0, 1);
      for (int n = 0; n < 6; n++) step(0, 4'h1, n[0], 1, 1, 0, 1);

      // Reset while overflowed, then saturate the drop counter.
      for (int n = 0; n < 12; n++) step(0, 4'h1, 1, 1, 0, 0, 1);
      step(1, 4'h1, 1, 1, 0, 0, 1);
      step(0, 4'h1, 0, 0, 0, 0, 1);
      chk("rst_cnt0", 64'(ocnt[0]), 64'd0);
      chk("rst_err1", 64'(err[1]), 64'd0);
      for (int n = 0; n < 310; n++) step(0, 4'h1, 1, 1, 0, 0, 1);
      @(negedge clk); #1;
      chk("sat_cnt0", 64'(ocnt[0]), 64'd255);
      chk("sat_cnt1", 64'(ocnt[1]), 64'd255);
      step(0, 4'h1, 1, 1, 1, 0, 1);

      // Randomised traffic with link drops, clears and occasional resets.
      up = 1; bias = 2;
      for (int n = 0; n < 3000; n++) begin
         if (n % 64 == 0) bias = $urandom_range(0, 4);
         if ($urandom_range(0, 49) == 0) up = !up;
         s_rand = 4'($urandom_range(0, 14));
         if (s_rand >= 4'd1) s_rand = s_rand + 4'd1;
         step($urandom_range(0, 199) == 0, up ? 4'h1 : s_rand,
              $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 3) < bias, $urandom_range(0, 15) == 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
